// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (7/8 data bits, optional parity, 1/2 stop) into a 1-entry holding register.
// Latency: data_valid rises one clk after the edge that decides the final stop bit; rxd adds 2 clk of sync delay.
// Backpressure: a single holding register; a completed character arriving while it is full and not handshaken is dropped and sets overrun.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority voting over samples M-1, M, M+1.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rx_enable,
    input  logic       parity_enable,
    input  logic       parity_odd,
    input  logic       data_len_7bit,
    input  logic       stop_2,
    input  logic       sample_tick,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    localparam int M = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
    // The majority needs sample M+1, so every decision is one tick later.
    localparam logic [3:0] DEC_CNT = 4'(M + 1);
`else
    localparam logic [3:0] DEC_CNT = 4'(M);
`endif
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

    // Synchroniser and sampled bit value
    logic rxd_m;
    logic rxd_s;
    logic bit_val;

    // Frame FSM state and datapath
    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] cnt_q;
    logic [3:0] cnt_nxt;
    logic [3:0] cnt_inc;
    logic [2:0] idx_q;
    logic [2:0] idx_nxt;
    logic [2:0] last_idx;
    logic [7:0] shreg_q;
    logic [7:0] shreg_nxt;
    logic       perr_q;
    logic       perr_nxt;
    logic       ferr_q;
    logic       ferr_nxt;
    logic       pbit_q;
    logic       pbit_nxt;
    logic       done_q;
    logic       done_nxt;
    logic       run;
    logic       decide;
    logic       handshake;
    logic       brk_calc;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Keep the two previous tick samples so the decision tick sees M-1, M and M+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (sample_tick) begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign bit_val = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign bit_val = rxd_s;
`endif

    assign run       = enable && rx_enable;
    assign decide    = sample_tick && (cnt_q == DEC_CNT);
    assign cnt_inc   = (cnt_q == LAST_CNT) ? 4'd0 : cnt_q + 4'd1;
    assign last_idx  = data_len_7bit ? 3'd6 : 3'd7;
    assign handshake = data_valid && data_ready;
    assign busy      = (state_q != IDLE);

    // Frame state register plus per-frame datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pbit_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            shreg_q <= shreg_nxt;
            perr_q  <= perr_nxt;
            ferr_q  <= ferr_nxt;
            pbit_q  <= pbit_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state logic: the sample counter wraps every OVERSAMPLE ticks, so a
    // bit is decided each time it passes DEC_CNT.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        shreg_nxt = shreg_q;
        perr_nxt  = perr_q;
        ferr_nxt  = ferr_q;
        pbit_nxt  = pbit_q;
        done_nxt  = 1'b0;

        if (!run) begin
            // Partial frame discarded; holding register untouched.
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            idx_nxt   = 3'd0;
        end else begin
            if (state_q != IDLE && sample_tick) begin
                cnt_nxt = cnt_inc;
            end
            unique case (state_q)
                IDLE: begin
                    if (sample_tick && !rxd_s) begin
                        // The detection tick is sample 0.
                        state_nxt = START;
                        cnt_nxt   = 4'd1;
                        idx_nxt   = 3'd0;
                        shreg_nxt = 8'd0;
                        perr_nxt  = 1'b0;
                        ferr_nxt  = 1'b0;
                        pbit_nxt  = 1'b0;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bit_val) begin
                            // False start: a short low glitch.
                            state_nxt = IDLE;
                            cnt_nxt   = 4'd0;
                        end else begin
                            state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg_nxt[idx_q] = bit_val;
                        if (idx_q == last_idx) begin
                            idx_nxt   = 3'd0;
                            state_nxt = parity_enable ? PARITY : STOP1;
                        end else begin
                            idx_nxt = idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        pbit_nxt  = bit_val;
                        perr_nxt  = bit_val != ((^shreg_q) ^ parity_odd);
                        state_nxt = STOP1;
                    end
                end
                STOP1: begin
                    if (decide) begin
                        if (!bit_val) begin
                            ferr_nxt = 1'b1;
                        end
                        if (stop_2) begin
                            state_nxt = STOP2;
                        end else begin
                            // Leave mid-stop-bit so the next start edge is not missed.
                            state_nxt = IDLE;
                            cnt_nxt   = 4'd0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (decide) begin
                        if (!bit_val) begin
                            ferr_nxt = 1'b1;
                        end
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Break: framing error with an all-zero character and a zero parity bit.
    assign brk_calc = ferr_q && (shreg_q == 8'd0) && !(parity_enable && pbit_q);

    // Holding register: load on completion unless full and not being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done_q) begin
                if (!data_valid || handshake) begin
                    data_out   <= shreg_q;
                    parity_err <= perr_q;
                    frame_err  <= ferr_q;
                    break_det  <= brk_calc;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                data_valid <= 1'b0;
            end
            if (handshake) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario bench for uart_rx at OVERSAMPLE = 16.
// Latency: sample_tick every 4 clk, so one bit lasts 64 clk.
// Backpressure: data_ready driven explicitly per scenario.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       rx_enable = 1'b1;
    logic       parity_enable = 1'b0;
    logic       parity_odd = 1'b0;
    logic       data_len_7bit = 1'b0;
    logic       stop_2 = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rxd = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int div = 0;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_enable(rx_enable),
        .parity_enable(parity_enable), .parity_odd(parity_odd),
        .data_len_7bit(data_len_7bit), .stop_2(stop_2),
        .sample_tick(sample_tick), .rxd(rxd), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready),
        .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = (div == 3) ? 0 : div + 1;
        sample_tick = (div == 0);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (sample_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic handshake();
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    // mode 0: plain; 1: handshake in the completion cycle; 2: check data_valid latency
    task automatic send_frame(input logic [7:0] d, input int nd, input int par,
                              input int nstop, input logic stop_val, input int mode);
        logic [15:0] fb;
        int n;
        int k;
        fb = '0;
        n = 1;
        for (int i = 0; i < nd; i++) begin
            fb[n] = d[i];
            n++;
        end
        if (par >= 0) begin
            fb[n] = par[0];
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            fb[n] = stop_val;
            n++;
        end
        for (int i = 0; i < n - 1; i++) begin
            rxd = fb[i];
            tick_wait(16);
        end
        rxd = fb[n-1];
        if (mode == 0) begin
            tick_wait(16);
        end else begin
            k = 0;
            while (busy === 1'b1 && k < 400) begin
                @(posedge clk);
                #1;
                k++;
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_fall got %b expected 0", busy);
            end
            if (mode == 1) begin
                handshake();
            end else begin
                checks++;
                if (data_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_early got %b expected 0", data_valid);
                end
                @(posedge clk);
                #1;
                checks++;
                if (data_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_latency got %b expected 1", data_valid);
                end
            end
            tick_wait(8);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({data_out, data_valid, parity_err, frame_err, break_det, overrun, busy} !== 14'd0) begin
            errors++;
            $display("FAIL reset_values got %h expected 0",
                     {data_out, data_valid, parity_err, frame_err, break_det, overrun, busy});
        end
        tick_wait(4);
    endtask

    task automatic test_8n1();
        send_frame(8'h55, 8, -1, 1, 1'b1, 2);
        checks++;
        if (data_out !== 8'h55) begin
            errors++;
            $display("FAIL 8n1_data got %h expected 55", data_out);
        end
        checks++;
        if ({parity_err, frame_err, break_det, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL 8n1_flags got %b expected 0000", {parity_err, frame_err, break_det, overrun});
        end
        handshake();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_clear got %b expected 0", data_valid);
        end
        tick_wait(8);
    endtask

    task automatic test_7e2();
        data_len_7bit = 1'b1;
        parity_enable = 1'b1;
        parity_odd = 1'b0;
        stop_2 = 1'b1;
        send_frame(8'h41, 7, 0, 2, 1'b1, 0);
        checks++;
        if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h41, 2'b00}) begin
            errors++;
            $display("FAIL 7e2_good got v=%b d=%h pe=%b fe=%b expected v=1 d=41 pe=0 fe=0",
                     data_valid, data_out, parity_err, frame_err);
        end
        handshake();
        tick_wait(4);
        send_frame(8'h41, 7, 1, 2, 1'b1, 0);
        checks++;
        if ({data_valid, data_out, parity_err} !== {1'b1, 8'h41, 1'b1}) begin
            errors++;
            $display("FAIL 7e2_bad_parity got v=%b d=%h pe=%b expected v=1 d=41 pe=1",
                     data_valid, data_out, parity_err);
        end
        handshake();
        data_len_7bit = 1'b0;
        parity_enable = 1'b0;
        stop_2 = 1'b0;
        tick_wait(8);
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        tick_wait(4);
        rxd = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got %b expected 1", busy);
        end
        tick_wait(16);
        checks++;
        if ({busy, data_valid} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_reject got busy=%b v=%b expected 0 0", busy, data_valid);
        end
    endtask

    task automatic test_frame_break();
        send_frame(8'hA5, 8, -1, 1, 1'b0, 0);
        tick_wait(32);
        checks++;
        if ({data_valid, data_out, frame_err, break_det} !== {1'b1, 8'hA5, 2'b10}) begin
            errors++;
            $display("FAIL frame_err got v=%b d=%h fe=%b bd=%b expected v=1 d=a5 fe=1 bd=0",
                     data_valid, data_out, frame_err, break_det);
        end
        handshake();
        send_frame(8'h00, 8, -1, 1, 1'b0, 0);
        tick_wait(32);
        checks++;
        if ({data_valid, data_out, frame_err, break_det} !== {1'b1, 8'h00, 2'b11}) begin
            errors++;
            $display("FAIL break got v=%b d=%h fe=%b bd=%b expected v=1 d=00 fe=1 bd=1",
                     data_valid, data_out, frame_err, break_det);
        end
        handshake();
        tick_wait(4);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 8, -1, 1, 1'b1, 0);
        tick_wait(4);
        send_frame(8'h22, 8, -1, 1, 1'b1, 0);
        tick_wait(4);
        checks++;
        if ({data_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b1}) begin
            errors++;
            $display("FAIL overrun_set got v=%b d=%h ov=%b expected v=1 d=11 ov=1",
                     data_valid, data_out, overrun);
        end
        handshake();
        checks++;
        if ({data_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clear got v=%b ov=%b expected 0 0", data_valid, overrun);
        end
        send_frame(8'h44, 8, -1, 1, 1'b1, 0);
        tick_wait(4);
        send_frame(8'h33, 8, -1, 1, 1'b1, 1);
        checks++;
        if ({data_valid, data_out, overrun} !== {1'b1, 8'h33, 1'b0}) begin
            errors++;
            $display("FAIL simul_handshake got v=%b d=%h ov=%b expected v=1 d=33 ov=0",
                     data_valid, data_out, overrun);
        end
        handshake();
        tick_wait(4);
    endtask

    task automatic test_disable();
        rxd = 1'b0;
        tick_wait(64);
        rx_enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL disable_busy got %b expected 0", busy);
        end
        rxd = 1'b1;
        tick_wait(2);
        rx_enable = 1'b1;
        tick_wait(160);
        checks++;
        if ({busy, data_valid} !== 2'b00) begin
            errors++;
            $display("FAIL disable_discard got busy=%b v=%b expected 0 0", busy, data_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h5A, 8, -1, 1, 1'b1, 0);
        tick_wait(4);
        send_frame(8'h5B, 8, -1, 1, 1'b1, 0);
        tick_wait(4);
        rxd = 1'b0;
        tick_wait(30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({data_out, data_valid, parity_err, frame_err, break_det, overrun, busy} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid got %h expected 0",
                     {data_out, data_valid, parity_err, frame_err, break_det, overrun, busy});
        end
        rst = 1'b0;
        rxd = 1'b1;
        tick_wait(32);
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        rxd = 1'b0;
        tick_wait(16);
        rxd = 1'b1;
        tick_wait(8);
        rxd = 1'b0;
        tick_wait(1);
        rxd = 1'b1;
        tick_wait(7);
        tick_wait(16 * 7);
        tick_wait(16);
        checks++;
        if ({data_valid, data_out, frame_err} !== {1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL majority got v=%b d=%h fe=%b expected v=1 d=ff fe=0",
                     data_valid, data_out, frame_err);
        end
        handshake();
        tick_wait(4);
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_glitch();
        test_frame_break();
        test_overrun();
        test_disable();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
